// File: rtl/cu_data_read_engine_control_if.sv
// Shared types and the bus interface of the CU read engine.
// The package carries the command/response/data line formats and the two
// helpers (cmd_size_calculate, map_CABT) used when building read commands.
package cu_read_engine_pkg;

  localparam int ARRAY_SIZE_BITS             = 32;
  localparam int CACHELINE_SIZE              = 128; // bytes per cacheline
  localparam int CACHELINE_ARRAY_NUM         = 32;  // 4-byte elements per cacheline
  localparam int DATA_READ_CONTROL_ID        = 1;
  localparam int READ_ENGINE_BUFFER_SIZE     = 16;
  localparam int READ_ENGINE_BUFFER_HEADROOM = 4;

  typedef enum logic [12:0] {
    NO_COMMAND = 13'h0000,
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50
  } psl_command_t;

  typedef enum logic [1:0] {
    CMD_INVALID = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2
  } cu_cmd_type_t;

  typedef enum logic [1:0] {
    STRUCT_INVALID = 2'd0,
    READ_DATA      = 2'd1,
    WRITE_DATA     = 2'd2
  } array_struct_t;

  typedef enum logic [2:0] {
    STRICT = 3'd0,
    ABORT  = 3'd1,
    PAGE   = 3'd2,
    PREF   = 3'd3,
    SPEC   = 3'd7
  } trans_order_behavior_t;

  typedef struct packed {
    logic [7:0]    cu_id;
    cu_cmd_type_t  cmd_type;
    array_struct_t array_struct;
    logic [31:0]   real_size;
    logic [31:0]   address_offest;
    logic [7:0]    cacheline_offest;
  } CommandTagLine;

  typedef struct packed {
    logic                  valid;
    psl_command_t          command;
    logic [63:0]           address;
    logic [11:0]           size;
    trans_order_behavior_t abt;
    CommandTagLine         cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic          valid;
    CommandTagLine cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic          valid;
    CommandTagLine cmd;
    logic [511:0]  data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  typedef struct packed {
    logic        valid;
    logic [63:0] array_send;
    logic [31:0] size_send;
  } WEDInterface;

  // Byte count of a partial cacheline read (4-byte elements).
  function automatic logic [11:0] cmd_size_calculate(input logic [31:0] elements);
    return 12'(elements << 2);
  endfunction

  // Translate the 3-bit config field into the PSL translation ordering code.
  function automatic trans_order_behavior_t map_CABT(input logic [2:0] abt_code);
    trans_order_behavior_t r;
    case (abt_code)
      3'd1:    r = ABORT;
      3'd2:    r = PAGE;
      3'd3:    r = PREF;
      3'd4:    r = SPEC;
      default: r = STRICT;
    endcase
    return r;
  endfunction

endpackage

// Handshake: every line is qualified by its own .valid for exactly one
// cycle per transfer; there is no ready. Flow control is carried by the
// BufferStatus almost-full flags, which the producer must honour before
// asserting valid (a push into a full buffer is dropped).
interface cu_read_engine_if;
  import cu_read_engine_pkg::*;

  CommandBufferLine  read_command_out;
  ResponseBufferLine read_response_in;
  ReadWriteDataLine  read_data_0_in;
  ReadWriteDataLine  read_data_1_in;
  ReadWriteDataLine  read_data_0_out;
  ReadWriteDataLine  read_data_1_out;
  BufferStatus       read_command_buffer_status;
  BufferStatus       read_data_out_buffer_status;
  BufferStatus       read_data_in_buffer_status;

  modport master (
    output read_command_out, read_data_0_out, read_data_1_out,
           read_data_in_buffer_status,
    input  read_response_in, read_data_0_in, read_data_1_in,
           read_command_buffer_status, read_data_out_buffer_status
  );

  modport slave (
    input  read_command_out, read_data_0_out, read_data_1_out,
           read_data_in_buffer_status,
    output read_response_in, read_data_0_in, read_data_1_in,
           read_command_buffer_status, read_data_out_buffer_status
  );
endinterface

// File: rtl/cu_data_read_engine_control.sv
// CU read engine control: walks the WED source array issuing cacheline
// read commands, counts completions, and pairs the two returning read-data
// half-lines for the compute unit.
// Optional macro CU_READ_ENGINE_PERF_EN enables the read_stall_cycles counter.

// Small FIFO holding one half-line stream; head is visible combinationally.
module cu_read_half_fifo
  import cu_read_engine_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int HEADROOM = 4
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  ReadWriteDataLine din,
  input  logic             pop,
  output ReadWriteDataLine dout,
  output logic             empty,
  output logic             full,
  output logic             alfull
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(DEPTH - HEADROOM);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  ReadWriteDataLine mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign alfull  = (count >= AF_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; data pushed while full is discarded.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module cu_data_read_engine_control
  import cu_read_engine_pkg::*;
#(
  parameter logic [7:0] CU_READ_CONTROL_ID = 8'(DATA_READ_CONTROL_ID),
  parameter int MAX_OUTSTANDING = 16,
  parameter int BUFFER_DEPTH    = READ_ENGINE_BUFFER_SIZE,
  parameter int BUFFER_HEADROOM = READ_ENGINE_BUFFER_HEADROOM
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       read_enabled_in,
  input  WEDInterface                wed_request_in,
  input  logic [63:0]                cu_configure,
  cu_read_engine_if.master           bus,
  output logic [ARRAY_SIZE_BITS-1:0] read_job_counter_done,
  output logic [31:0]                read_stall_cycles,
  output logic [2:0]                 read_engine_state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_WED = 3'd1,
    ISSUE    = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_OUTSTANDING);

  state_t           state, state_n;
  logic             enabled_q;
  WEDInterface      wed_q;
  logic [63:0]      cfg_q;
  logic [31:0]      remaining, offset, real_size;
  logic [OW-1:0]    outstanding;
  logic             issue_go, pop;
  ReadWriteDataLine f0_dout, f1_dout;
  logic             f0_empty, f0_full, f0_alfull;
  logic             f1_empty, f1_full, f1_alfull;

  assign read_engine_state = state;

  // A command carries at most one cacheline worth of elements.
  assign real_size = (remaining < 32'(CACHELINE_ARRAY_NUM)) ? remaining
                                                             : 32'(CACHELINE_ARRAY_NUM);
  assign issue_go  = (state == ISSUE) && enabled_q && (remaining != '0) &&
                     !bus.read_command_buffer_status.alfull && (outstanding < MAX_C);
  assign pop       = enabled_q && !f0_empty && !f1_empty &&
                     !bus.read_data_out_buffer_status.alfull;

  // State register.
  always_ff @(posedge clock) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic for the issue sequence.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (enabled_q) state_n = WAIT_WED;
      WAIT_WED: if (wed_q.valid && cfg_q[21]) state_n = ISSUE;
      ISSUE:    if (remaining == '0) state_n = DRAIN;
      DRAIN:    if (outstanding == '0) state_n = DONE;
      DONE:     if (!enabled_q) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Enable, WED/config latches, walk pointers and the registered command.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      enabled_q            <= 1'b0;
      wed_q                <= '0;
      cfg_q                <= '0;
      remaining            <= '0;
      offset               <= '0;
      bus.read_command_out <= '0;
    end else begin
      enabled_q <= read_enabled_in;
      if (enabled_q && wed_request_in.valid && !wed_q.valid) wed_q <= wed_request_in;
      if (cu_configure != '0) cfg_q <= cu_configure;

      if (state == WAIT_WED && state_n == ISSUE) begin
        remaining <= wed_q.size_send;
        offset    <= '0;
      end else if (issue_go) begin
        remaining <= remaining - real_size;
        offset    <= offset + 32'(CACHELINE_SIZE);
      end

      bus.read_command_out <= '0;
      if (issue_go) begin
        bus.read_command_out.valid                <= 1'b1;
        bus.read_command_out.command              <= cfg_q[9] ? READ_CL_S : READ_CL_NA;
        bus.read_command_out.address              <= wed_q.array_send + {32'b0, offset};
        bus.read_command_out.size                 <= cfg_q[9] ? 12'h080 : cmd_size_calculate(real_size);
        bus.read_command_out.abt                  <= map_CABT(cfg_q[7:5]);
        bus.read_command_out.cmd.cu_id            <= CU_READ_CONTROL_ID;
        bus.read_command_out.cmd.cmd_type         <= CMD_READ;
        bus.read_command_out.cmd.array_struct     <= READ_DATA;
        bus.read_command_out.cmd.real_size        <= real_size;
        bus.read_command_out.cmd.address_offest   <= offset;
        bus.read_command_out.cmd.cacheline_offest <= '0;
      end
    end
  end

  // Outstanding commands and confirmed element count; a response arriving
  // with nothing outstanding (e.g. after a reset) still counts as done work.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      outstanding           <= '0;
      read_job_counter_done <= '0;
    end else begin
      case ({issue_go, bus.read_response_in.valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (bus.read_response_in.valid)
        read_job_counter_done <= read_job_counter_done + bus.read_response_in.cmd.real_size;
    end
  end

  cu_read_half_fifo #(.DEPTH(BUFFER_DEPTH), .HEADROOM(BUFFER_HEADROOM)) u_fifo_0 (
    .clock  (clock),
    .rstn   (rstn),
    .push   (bus.read_data_0_in.valid),
    .din    (bus.read_data_0_in),
    .pop    (pop),
    .dout   (f0_dout),
    .empty  (f0_empty),
    .full   (f0_full),
    .alfull (f0_alfull)
  );

  cu_read_half_fifo #(.DEPTH(BUFFER_DEPTH), .HEADROOM(BUFFER_HEADROOM)) u_fifo_1 (
    .clock  (clock),
    .rstn   (rstn),
    .push   (bus.read_data_1_in.valid),
    .din    (bus.read_data_1_in),
    .pop    (pop),
    .dout   (f1_dout),
    .empty  (f1_empty),
    .full   (f1_full),
    .alfull (f1_alfull)
  );

  // Paired output stage and the half-0 buffer status seen by the PSL side.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      bus.read_data_0_out            <= '0;
      bus.read_data_1_out            <= '0;
      bus.read_data_in_buffer_status <= '0;
    end else begin
      bus.read_data_0_out <= '0;
      bus.read_data_1_out <= '0;
      if (pop) begin
        bus.read_data_0_out       <= f0_dout;
        bus.read_data_0_out.valid <= 1'b1;
        bus.read_data_1_out       <= f1_dout;
        bus.read_data_1_out.valid <= 1'b1;
      end
      bus.read_data_in_buffer_status.empty  <= f0_empty;
      bus.read_data_in_buffer_status.alfull <= f0_alfull;
      bus.read_data_in_buffer_status.full   <= f0_full;
    end
  end

`ifdef CU_READ_ENGINE_PERF_EN
  logic issue_stall;
  assign issue_stall = (state == ISSUE) && (remaining != '0) &&
                       (bus.read_command_buffer_status.alfull || (outstanding >= MAX_C));

  // Saturating count of cycles where issue was wanted but blocked.
  always_ff @(posedge clock) begin
    if (!rstn) read_stall_cycles <= '0;
    else if (issue_stall && (read_stall_cycles != 32'hFFFF_FFFF))
      read_stall_cycles <= read_stall_cycles + 32'd1;
  end
`else
  assign read_stall_cycles = '0;
`endif

  // Fields carried through the interfaces that this block does not consume.
  logic unused_sigs;
  assign unused_sigs = ^{cfg_q, bus.read_response_in, bus.read_command_buffer_status,
                         bus.read_data_out_buffer_status, f0_dout.valid, f1_dout.valid,
                         f1_alfull, f1_full};
endmodule

// File: tb/tb_cu_data_read_engine_control.sv
// Directed bench for cu_data_read_engine_control: command issue, outstanding
// limit, completion counting, half-line pairing, back-pressure, overflow and
// reset. Expected values are hand-computed constants.
module tb_cu_data_read_engine_control;
  import cu_read_engine_pkg::*;

  localparam logic [63:0] CFG_NA = 64'h0000_0000_0020_0040; // [21]=1, abt=2
  localparam logic [63:0] CFG_S  = 64'h0000_0000_0020_0240; // plus [9]=1
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_ISSUE = 3'd2;
  localparam logic [2:0]  ST_DONE  = 3'd4;

  logic        clock;
  logic        rstn;
  logic        read_enabled_in;
  WEDInterface wed_request_in;
  logic [63:0] cu_configure;
  logic [31:0] read_job_counter_done;
  logic [31:0] read_stall_cycles;
  logic [2:0]  read_engine_state;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [511:0] exp0_q[$];
  logic [511:0] exp1_q[$];

  cu_read_engine_if bus ();

  cu_data_read_engine_control #(
    .CU_READ_CONTROL_ID (8'h5A),
    .MAX_OUTSTANDING    (3),
    .BUFFER_DEPTH       (8),
    .BUFFER_HEADROOM    (4)
  ) dut (
    .clock                 (clock),
    .rstn                  (rstn),
    .read_enabled_in       (read_enabled_in),
    .wed_request_in        (wed_request_in),
    .cu_configure          (cu_configure),
    .bus                   (bus.master),
    .read_job_counter_done (read_job_counter_done),
    .read_stall_cycles     (read_stall_cycles),
    .read_engine_state     (read_engine_state)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic do_reset();
    rstn = 1'b0;
    read_enabled_in = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic start(input logic [63:0] addr, input logic [31:0] size, input logic [63:0] cfg);
    wed_request_in.valid      = 1'b1;
    wed_request_in.array_send = addr;
    wed_request_in.size_send  = size;
    cu_configure              = cfg;
    read_enabled_in           = 1'b1;
  endtask

  task automatic respond(input logic [31:0] n);
    ResponseBufferLine r;
    r = '0;
    r.valid = 1'b1;
    r.cmd.real_size = n;
    bus.read_response_in = r;
    tick();
    bus.read_response_in = '0;
  endtask

  task automatic push_pair(input logic [511:0] d0, input logic [511:0] d1);
    ReadWriteDataLine l;
    l = '0;
    l.valid = 1'b1;
    l.data = d0;
    bus.read_data_0_in = l;
    l.data = d1;
    bus.read_data_1_in = l;
    tick();
    bus.read_data_0_in = '0;
    bus.read_data_1_in = '0;
  endtask

  task automatic wait_cmd(input string tag, output CommandBufferLine c);
    bit seen;
    seen = 1'b0;
    c = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.read_command_out.valid) begin
        c = bus.read_command_out;
        seen = 1'b1;
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic count_cmds(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.read_command_out.valid) cnt++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_valid"}, 64'(bus.read_command_out.valid), 64'd0);
    check({tag, "_d0_valid"}, 64'(bus.read_data_0_out.valid), 64'd0);
    check({tag, "_d1_valid"}, 64'(bus.read_data_1_out.valid), 64'd0);
    check({tag, "_in_status"}, 64'(bus.read_data_in_buffer_status), 64'd0);
    check({tag, "_done_cnt"}, 64'(read_job_counter_done), 64'd0);
    check({tag, "_stall"}, 64'(read_stall_cycles), 64'd0);
    check({tag, "_state"}, 64'(read_engine_state), 64'(ST_IDLE));
  endtask

  initial begin
    CommandBufferLine c;
    ReadWriteDataLine l;
    int cnt;
    logic [511:0] da, db;

    rstn = 1'b0;
    read_enabled_in = 1'b0;
    wed_request_in = '0;
    cu_configure = '0;
    bus.read_response_in = '0;
    bus.read_data_0_in = '0;
    bus.read_data_1_in = '0;
    bus.read_command_buffer_status = '0;
    bus.read_data_out_buffer_status = '0;
    tick();
    tick();
    check_outputs_zero("reset");

    // 64 elements: two full cachelines, READ_CL_NA.
    do_reset();
    start(64'h1000, 32'd64, CFG_NA);
    wait_cmd("t1_c0", c);
    check("t1_c0_addr", c.address, 64'h1000);
    check("t1_c0_real", 64'(c.cmd.real_size), 64'd32);
    check("t1_c0_size", 64'(c.size), 64'h080);
    check("t1_c0_command", 64'(c.command), 64'(READ_CL_NA));
    check("t1_c0_cu_id", 64'(c.cmd.cu_id), 64'h5A);
    check("t1_c0_type", 64'(c.cmd.cmd_type), 64'(CMD_READ));
    check("t1_c0_struct", 64'(c.cmd.array_struct), 64'(READ_DATA));
    check("t1_c0_abt", 64'(c.abt), 64'(PAGE));
    check("t1_c0_offset", 64'(c.cmd.address_offest), 64'd0);
    wait_cmd("t1_c1", c);
    check("t1_c1_addr", c.address, 64'h1080);
    check("t1_c1_offset", 64'(c.cmd.address_offest), 64'h80);
    check("t1_c1_real", 64'(c.cmd.real_size), 64'd32);
    respond(32'd32);
    respond(32'd32);
    tick();
    tick();
    check("t1_done_cnt", 64'(read_job_counter_done), 64'd64);
    check("t1_state_done", 64'(read_engine_state), 64'(ST_DONE));

    // 40 elements: 32 then 8, partial size on the tail.
    do_reset();
    start(64'h1000, 32'd40, CFG_NA);
    wait_cmd("t2_c0", c);
    check("t2_c0_real", 64'(c.cmd.real_size), 64'd32);
    check("t2_c0_size", 64'(c.size), 64'h080);
    wait_cmd("t2_c1", c);
    check("t2_c1_addr", c.address, 64'h1080);
    check("t2_c1_real", 64'(c.cmd.real_size), 64'd8);
    check("t2_c1_size", 64'(c.size), 64'h020);
    check("t2_c1_command", 64'(c.command), 64'(READ_CL_NA));

    // Same walk with READ_CL_S: always full-cacheline size.
    do_reset();
    start(64'h2000, 32'd40, CFG_S);
    wait_cmd("t2s_c0", c);
    check("t2s_c0_size", 64'(c.size), 64'h080);
    check("t2s_c0_command", 64'(c.command), 64'(READ_CL_S));
    wait_cmd("t2s_c1", c);
    check("t2s_c1_addr", c.address, 64'h2080);
    check("t2s_c1_real", 64'(c.cmd.real_size), 64'd8);
    check("t2s_c1_size", 64'(c.size), 64'h080);
    check("t2s_c1_command", 64'(c.command), 64'(READ_CL_S));

    // Blocked issue, outstanding limit of 3, then reset mid-walk.
    do_reset();
    bus.read_command_buffer_status.alfull = 1'b1;
    start(64'h4000, 32'd160, CFG_NA);
    cnt = 0;
    for (int i = 0; i < 20 && read_engine_state != ST_ISSUE; i++) tick();
    check("t3_reach_issue", 64'(read_engine_state), 64'(ST_ISSUE));
    check("t3_stall_start", 64'(read_stall_cycles), 64'd0);
    count_cmds(5, cnt);
    check("t3_no_cmd_blocked", 64'(cnt), 64'd0);
`ifdef CU_READ_ENGINE_PERF_EN
    check("t3_stall_5", 64'(read_stall_cycles), 64'd5);
`else
    check("t3_stall_off", 64'(read_stall_cycles), 64'd0);
`endif
    bus.read_command_buffer_status.alfull = 1'b0;
    count_cmds(20, cnt);
    check("t3_limit_cmds", 64'(cnt), 64'd3);
    respond(32'd32);
    count_cmds(20, cnt);
    check("t3_after_resp_cmds", 64'(cnt), 64'd1);
    check("t3_still_issue", 64'(read_engine_state), 64'(ST_ISSUE));
    rstn = 1'b0;
    tick();
    check_outputs_zero("t6_midreset");
    rstn = 1'b1;
    read_enabled_in = 1'b0;
    respond(32'd32);
    check("t6_late_resp", 64'(read_job_counter_done), 64'd32);

    // Pairing: halves arrive three cycles apart.
    do_reset();
    wed_request_in = '0;
    cu_configure = '0;
    read_enabled_in = 1'b1;
    tick();
    tick();
    da = {16{32'hA5A5_0001}};
    db = {16{32'h5A5A_0002}};
    l = '0;
    l.valid = 1'b1;
    l.data = da;
    bus.read_data_0_in = l;
    tick();
    bus.read_data_0_in = '0;
    check("t4_half0_only", 64'(bus.read_data_0_out.valid), 64'd0);
    tick();
    tick();
    check("t4_still_waiting", 64'(bus.read_data_0_out.valid), 64'd0);
    l.data = db;
    bus.read_data_1_in = l;
    tick();
    bus.read_data_1_in = '0;
    check("t4_pushed_not_out", 64'(bus.read_data_0_out.valid), 64'd0);
    tick();
    check("t4_out0_valid", 64'(bus.read_data_0_out.valid), 64'd1);
    check("t4_out1_valid", 64'(bus.read_data_1_out.valid), 64'd1);
    check_data("t4_out0_data", bus.read_data_0_out.data, da);
    check_data("t4_out1_data", bus.read_data_1_out.data, db);
    tick();
    check("t4_single_pulse", 64'(bus.read_data_0_out.valid), 64'd0);

    // Consumer back-pressure with 4 pairs queued.
    bus.read_data_out_buffer_status.alfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp0_q.push_back({16{32'(i + 16)}});
      exp1_q.push_back({16{32'(i + 48)}});
      push_pair({16{32'(i + 16)}}, {16{32'(i + 48)}});
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.read_data_0_out.valid || bus.read_data_1_out.valid) cnt++;
    end
    check("t5_held", 64'(cnt), 64'd0);
    check("t5_in_alfull", 64'(bus.read_data_in_buffer_status.alfull), 64'd1);
    check("t5_in_not_empty", 64'(bus.read_data_in_buffer_status.empty), 64'd0);
    bus.read_data_out_buffer_status.alfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_pair_valid", 64'(bus.read_data_0_out.valid & bus.read_data_1_out.valid), 64'd1);
      check_data("t5_pair_d0", bus.read_data_0_out.data, exp0_q.pop_front());
      check_data("t5_pair_d1", bus.read_data_1_out.data, exp1_q.pop_front());
    end
    tick();
    check("t5_drained", 64'(bus.read_data_0_out.valid), 64'd0);
    tick();
    check("t5_in_empty", 64'(bus.read_data_in_buffer_status.empty), 64'd1);

    // Overflow: 9 pairs into depth-8 FIFOs; the 9th is dropped.
    bus.read_data_out_buffer_status.alfull = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        exp0_q.push_back({16{32'(i + 100)}});
        exp1_q.push_back({16{32'(i + 200)}});
      end
      push_pair({16{32'(i + 100)}}, {16{32'(i + 200)}});
    end
    check("t7_in_full", 64'(bus.read_data_in_buffer_status.full), 64'd1);
    bus.read_data_out_buffer_status.alfull = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.read_data_0_out.valid) begin
        cnt++;
        if (exp0_q.size() > 0) begin
          check_data("t7_pair_d0", bus.read_data_0_out.data, exp0_q.pop_front());
          check_data("t7_pair_d1", bus.read_data_1_out.data, exp1_q.pop_front());
        end
      end
    end
    check("t7_pair_count", 64'(cnt), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
